// File: rtl/mips_pkg.sv
// Shared types and constants for the wait-state multicycle MIPS controller:
// FSM states, opcode/funct encodings, ALU op/control codes and fault codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_LBRD,
    S_LBWR,
    S_SBWR,
    S_RTYPEEX,
    S_RTYPEWR,
    S_BEQEX,
    S_BNEEX,
    S_ADDIEX,
    S_ADDIWR,
    S_JEX,
    S_FAULT
  } statetype;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LB    = 6'b100000,
    OP_SB    = 6'b101000
  } opcode;

  typedef enum logic [5:0] {
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_SLT = 6'b101010
  } functcode;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD   = 3'b010;
  localparam logic [2:0] ALUCTL_SUB   = 3'b110;
  localparam logic [2:0] ALUCTL_AND   = 3'b000;
  localparam logic [2:0] ALUCTL_OR    = 3'b001;
  localparam logic [2:0] ALUCTL_SLT   = 3'b111;
  localparam logic [2:0] ALUCTL_UNDEF = 3'b101;

  // States that issue a memory request and therefore wait on mem_ready.
  function automatic logic is_mem_state(statetype s);
    return (s == S_FETCH) || (s == S_LBRD) || (s == S_SBWR);
  endfunction

endpackage

// File: rtl/mips_ctrl_ws_if.sv
// Controller <-> datapath/memory bundle: instruction fields and status in,
// datapath control strobes, memory requests and fault status out.
interface mips_ctrl_ws_if #(
  parameter int IR_BEATS = 4
);
  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;

  logic                memread;
  logic                memwrite;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic                memtoreg;
  logic                iord;
  logic                regwrite;
  logic                regdst;
  logic [1:0]          pcsrc;
  logic                pcen;
  logic [2:0]          alucontrol;
  logic [IR_BEATS-1:0] irwrite;
  logic                halted;
  logic [1:0]          fault_code;

  modport master (
    input  op, funct, zero, mem_ready,
    output memread, memwrite, alusrca, alusrcb, memtoreg, iord, regwrite,
           regdst, pcsrc, pcen, alucontrol, irwrite, halted, fault_code
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  memread, memwrite, alusrca, alusrcb, memtoreg, iord, regwrite,
           regdst, pcsrc, pcen, alucontrol, irwrite, halted, fault_code
  );
endinterface

// File: rtl/mips_alu_dec.sv
// ALU control decode: fixed add/sub for address and branch compare,
// funct-driven operation for R-type instructions.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALUCTL_UNDEF;
    if (aluop == ALUOP_ADD) begin
      alucontrol = ALUCTL_ADD;
    end else if (aluop == ALUOP_SUB) begin
      alucontrol = ALUCTL_SUB;
    end else begin
      case (funct)
        FN_ADD:  alucontrol = ALUCTL_ADD;
        FN_SUB:  alucontrol = ALUCTL_SUB;
        FN_AND:  alucontrol = ALUCTL_AND;
        FN_OR:   alucontrol = ALUCTL_OR;
        FN_SLT:  alucontrol = ALUCTL_SLT;
        default: alucontrol = ALUCTL_UNDEF;
      endcase
    end
  end

endmodule

// File: rtl/mips_ctrl_ws.sv
// Multicycle MIPS controller with memory wait states, multi-beat instruction
// fetch, ADDI/BNE support, bus-timeout detection and a sticky FAULT state.
module mips_ctrl_ws
  import mips_pkg::*;
#(
  parameter int IR_BEATS    = 4,   // 1, 2 or 4 fetch beats per instruction
  parameter int BUS_TIMEOUT = 15   // 0 disables the timeout check
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_ctrl_ws_if.master bus
);

  localparam int BEAT_W = (IR_BEATS > 1) ? $clog2(IR_BEATS) : 1;
  localparam int TMO_W  = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IR_BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(BUS_TIMEOUT);

  statetype          state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  fault_e            fault_q, fault_d;

  logic                memread_c, memwrite_c, alusrca_c, memtoreg_c;
  logic                iord_c, regwrite_c, regdst_c;
  logic                pcwrite_c, branch_c, branchn_c;
  logic [1:0]          alusrcb_c, pcsrc_c, aluop_c;
  logic [IR_BEATS-1:0] irwrite_c;
  logic [2:0]          alucontrol_c;
  logic                mem_wait;

  mips_alu_dec u_alu_dec (
    .funct      (bus.funct),
    .aluop      (aluop_c),
    .alucontrol (alucontrol_c)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d input, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      beat_q  <= '0;
      tmo_q   <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: every signal written here gets a default first; without it a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tmo_d      = '0;
    fault_d    = fault_q;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    memtoreg_c = 1'b0;
    iord_c     = 1'b0;
    regwrite_c = 1'b0;
    regdst_c   = 1'b0;
    pcsrc_c    = 2'b00;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    branchn_c  = 1'b0;
    aluop_c    = ALUOP_ADD;
    irwrite_c  = '0;
    mem_wait   = is_mem_state(state_q) && !bus.mem_ready;

    case (state_q)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        if (bus.mem_ready) begin
          irwrite_c = IR_BEATS'(1) << beat_q;
          pcwrite_c = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_DECODE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (bus.op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d = S_FAULT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = (bus.op == OP_LB) ? S_LBRD : S_SBWR;
      end
      S_LBRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        if (bus.mem_ready) state_d = S_LBWR;
      end
      S_LBWR: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_SBWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_c = 1'b1;
        aluop_c   = ALUOP_FUNCT;
        state_d   = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca_c = 1'b1;
        aluop_c   = ALUOP_SUB;
        pcsrc_c   = 2'b01;
        branch_c  = (state_q == S_BEQEX);
        branchn_c = (state_q == S_BNEEX);
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = S_ADDIWR;
      end
      S_ADDIWR: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcwrite_c = 1'b1;
        pcsrc_c   = 2'b10;
        state_d   = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // A ready in the limit cycle completes the access, so only a still-waiting
    // request at the limit trips the timeout.
    if (mem_wait && (BUS_TIMEOUT != 0)) begin
      if (tmo_q == TMO_LIMIT) begin
        state_d = S_FAULT;
        fault_d = FAULT_TIMEOUT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // Outputs are forced low while reset is held so an aborted access drops
  // its request without waiting for a clock edge. Idle states keep the ALU on
  // add for the PC incrementer; FAULT silences it too.
  always_comb begin
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.memtoreg   = 1'b0;
    bus.iord       = 1'b0;
    bus.regwrite   = 1'b0;
    bus.regdst     = 1'b0;
    bus.pcsrc      = 2'b00;
    bus.pcen       = 1'b0;
    bus.alucontrol = 3'b000;
    bus.irwrite    = '0;
    bus.halted     = 1'b0;
    bus.fault_code = FAULT_NONE;
    if (rst_n) begin
      bus.memread    = memread_c;
      bus.memwrite   = memwrite_c;
      bus.alusrca    = alusrca_c;
      bus.alusrcb    = alusrcb_c;
      bus.memtoreg   = memtoreg_c;
      bus.iord       = iord_c;
      bus.regwrite   = regwrite_c;
      bus.regdst     = regdst_c;
      bus.pcsrc      = pcsrc_c;
      bus.pcen       = pcwrite_c | (branch_c & bus.zero) | (branchn_c & ~bus.zero);
      bus.alucontrol = (state_q == S_FAULT) ? 3'b000 : alucontrol_c;
      bus.irwrite    = irwrite_c;
      bus.halted     = (state_q == S_FAULT);
      bus.fault_code = fault_q;
    end
  end

endmodule

// File: tb/tb_mips_ctrl_ws.sv
// Directed scoreboard bench for mips_ctrl_ws: expected control words are queued
// as each cycle's stimulus is applied and compared when the outputs settle.
module tb_mips_ctrl_ws;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mips_ctrl_ws_if #(.IR_BEATS(4)) bus ();

  mips_ctrl_ws #(.IR_BEATS(4), .BUS_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic [3:0] irwrite;
    logic       halted;
    logic [1:0] fault_code;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  exp;
  } sb_t;

  typedef enum {
    X_RESET, X_FETCH, X_DECODE, X_MEMADR, X_LBRD, X_LBWR, X_SBWR,
    X_RTYPEEX, X_RTYPEWR, X_BEQEX, X_BNEEX, X_ADDIEX, X_ADDIWR, X_JEX,
    X_FAULT_ILL, X_FAULT_TMO
  } xs_e;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // Expected outputs of each state as the controller is documented to behave.
  function automatic ctl_t model(xs_e s, bit rdy = 1'b1, int beat = 0,
                                 bit z = 1'b0, logic [2:0] rctl = 3'b010);
    ctl_t e;
    e = '0;
    e.alucontrol = 3'b010;
    case (s)
      X_RESET: e = '0;
      X_FETCH: begin
        e.memread = 1'b1;
        e.alusrcb = 2'b01;
        if (rdy) begin
          e.irwrite = 4'(1 << beat);
          e.pcen    = 1'b1;
        end
      end
      X_DECODE:  e.alusrcb = 2'b11;
      X_MEMADR:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      X_LBRD:    begin e.memread = 1'b1; e.iord = 1'b1; end
      X_LBWR:    begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
      X_SBWR:    begin e.memwrite = 1'b1; e.iord = 1'b1; end
      X_RTYPEEX: begin e.alusrca = 1'b1; e.alucontrol = rctl; end
      X_RTYPEWR: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      X_BEQEX, X_BNEEX: begin
        e.alusrca    = 1'b1;
        e.alucontrol = 3'b110;
        e.pcsrc      = 2'b01;
        e.pcen       = (s == X_BEQEX) ? z : ~z;
      end
      X_ADDIEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      X_ADDIWR:  e.regwrite = 1'b1;
      X_JEX:     begin e.pcen = 1'b1; e.pcsrc = 2'b10; end
      X_FAULT_ILL: begin e = '0; e.halted = 1'b1; e.fault_code = 2'b01; end
      X_FAULT_TMO: begin e = '0; e.halted = 1'b1; e.fault_code = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic ctl_t observed();
    ctl_t o;
    o.memread    = bus.memread;
    o.memwrite   = bus.memwrite;
    o.alusrca    = bus.alusrca;
    o.alusrcb    = bus.alusrcb;
    o.memtoreg   = bus.memtoreg;
    o.iord       = bus.iord;
    o.regwrite   = bus.regwrite;
    o.regdst     = bus.regdst;
    o.pcsrc      = bus.pcsrc;
    o.pcen       = bus.pcen;
    o.alucontrol = bus.alucontrol;
    o.irwrite    = bus.irwrite;
    o.halted     = bus.halted;
    o.fault_code = bus.fault_code;
    return o;
  endfunction

  task automatic expect_push(string tag, ctl_t e);
    sb.push_back('{tag, e});
  endtask

  task automatic check(ctl_t obs);
    sb_t it;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty got=%h want=<none>", obs);
    end else begin
      it = sb.pop_front();
      checks++;
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s got=%h want=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  // One clock: queue the expectation, sample at the falling edge, then move
  // to just after the next rising edge where new stimulus is applied.
  task automatic step(string tag, ctl_t e);
    expect_push(tag, e);
    @(negedge clk);
    check(observed());
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_all(string tag);
    for (int b = 0; b < 4; b++) step(tag, model(X_FETCH, 1'b1, b));
  endtask

  initial begin
    logic [5:0] fn_list [5];
    logic [2:0] ctl_list [5];
    fn_list  = '{FN_SUB, FN_AND, FN_OR, FN_SLT, 6'b000111};
    ctl_list = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b101};

    bus.op        = OP_RTYPE;
    bus.funct     = FN_ADD;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    step("reset_outputs", model(X_RESET));
    rst_n = 1'b1;

    // R-type ADD through the full sequence
    fetch_all("rtype_fetch");
    step("rtype_decode", model(X_DECODE));
    step("rtype_ex_add", model(X_RTYPEEX, 1'b1, 0, 1'b0, 3'b010));
    step("rtype_wr", model(X_RTYPEWR));

    for (int i = 0; i < 5; i++) begin
      bus.funct = fn_list[i];
      fetch_all("funct_fetch");
      step("funct_decode", model(X_DECODE));
      step($sformatf("funct_ex_%0d", i), model(X_RTYPEEX, 1'b1, 0, 1'b0, ctl_list[i]));
      step("funct_wr", model(X_RTYPEWR));
    end

    // ADDI with a three-cycle stall on fetch beat 2
    bus.op = OP_ADDI;
    step("ws_beat0", model(X_FETCH, 1'b1, 0));
    step("ws_beat1", model(X_FETCH, 1'b1, 1));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("ws_stall", model(X_FETCH, 1'b0, 2));
    bus.mem_ready = 1'b1;
    step("ws_beat2", model(X_FETCH, 1'b1, 2));
    step("ws_beat3", model(X_FETCH, 1'b1, 3));
    step("addi_decode", model(X_DECODE));
    step("addi_ex", model(X_ADDIEX));
    step("addi_wr", model(X_ADDIWR));

    // Branch polarity for BNE and BEQ
    for (int k = 0; k < 4; k++) begin
      bus.op   = (k < 2) ? OP_BNE : OP_BEQ;
      bus.zero = (k % 2 == 0);
      fetch_all("br_fetch");
      step("br_decode", model(X_DECODE));
      if (k < 2) step($sformatf("bne_ex_z%0d", bus.zero), model(X_BNEEX, 1'b1, 0, bus.zero));
      else       step($sformatf("beq_ex_z%0d", bus.zero), model(X_BEQEX, 1'b1, 0, bus.zero));
    end
    bus.zero = 1'b0;

    bus.op = OP_J;
    fetch_all("j_fetch");
    step("j_decode", model(X_DECODE));
    step("j_ex", model(X_JEX));

    // SB with two wait cycles
    bus.op = OP_SB;
    fetch_all("sb_fetch");
    step("sb_decode", model(X_DECODE));
    step("sb_memadr", model(X_MEMADR));
    bus.mem_ready = 1'b0;
    step("sb_wait0", model(X_SBWR));
    step("sb_wait1", model(X_SBWR));
    bus.mem_ready = 1'b1;
    step("sb_done", model(X_SBWR));

    // LB read timing out after 16 not-ready cycles
    bus.op = OP_LB;
    fetch_all("lbt_fetch");
    step("lbt_decode", model(X_DECODE));
    step("lbt_memadr", model(X_MEMADR));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step($sformatf("lbt_wait%0d", i), model(X_LBRD));
    for (int i = 0; i < 3; i++) step("lbt_fault", model(X_FAULT_TMO));
    rst_n = 1'b0;
    #1;
    expect_push("lbt_reset", model(X_RESET));
    check(observed());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;

    // Same read, ready arrives on the 16th cycle
    fetch_all("lbr_fetch");
    step("lbr_decode", model(X_DECODE));
    step("lbr_memadr", model(X_MEMADR));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("lbr_wait", model(X_LBRD));
    bus.mem_ready = 1'b1;
    step("lbr_ready16", model(X_LBRD));
    step("lbr_wr", model(X_LBWR));

    // Illegal opcode sticks in FAULT regardless of mem_ready
    bus.op = 6'b111111;
    fetch_all("ill_fetch");
    step("ill_decode", model(X_DECODE));
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = (i % 2 == 0);
      step($sformatf("ill_fault%0d", i), model(X_FAULT_ILL));
    end
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.op = OP_SB;
    #1;
    expect_push("ill_reset", model(X_RESET));
    check(observed());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("ill_refetch", model(X_FETCH, 1'b1, 0));
    for (int b = 1; b < 4; b++) step("sba_fetch", model(X_FETCH, 1'b1, b));

    // Reset asserted between edges while SB waits
    step("sba_decode", model(X_DECODE));
    step("sba_memadr", model(X_MEMADR));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("sba_wait", model(X_SBWR));
    #2;
    rst_n = 1'b0;
    #1;
    expect_push("sba_async_drop", model(X_RESET));
    check(observed());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    step("sba_first_beat", model(X_FETCH, 1'b1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
